key_steer: RTL and testbench
============================

# key_steer

Upstream input stage for the snake game: converts the two raw push-buttons into absolute direction codes for the game logic. Each button press is synchronised, debounced, and treated as a relative steer: `btn` turns left, `btn1` turns right. The block tracks the current heading and emits the new absolute key code with a one-cycle `keydown` strobe. Its `code`/`keydown` outputs drive the game block's `code`/`keydown` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive cycles a synchronised level must differ from the stable level before it is accepted; legal range ≥ 2.
- `clk` input 1: pixel/system clock from the PLL; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `btn` input 1: raw button, active-low (0 = pressed); steer left.
- `btn1` input 1: raw button, active-low; steer right.
- `restart` input 1: one-cycle pulse; forces heading back to Right, for example on game restart.
- `code` output 4: current absolute heading. Key_Left=4'h2, Key_Right=4'h4, Key_Down=4'h3, Key_Up=4'h7.
- `keydown` output 1: one-cycle strobe; high on the cycle `code` takes a new heading from a press.

## Operation
- Per button: 2-flop synchroniser (reset value 1), then debounce counter (width $clog2(DEBOUNCE_CYCLES), reset 0), then `stable` register (reset 1 = released).
- Debounce, each cycle:
  - sync == stable → counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1 → stable <= sync and counter <= 0.
  - Otherwise → counter++.
  - Any bounce back to the stable level before the count completes restarts the count.
- Press event = `stable` 1→0 transition, detected from a registered copy of `stable`. Releases produce no event.
- Heading register, reset value Right. Its value is driven onto `code`.
- Rotation rules:
  - Left press (CCW): Up→Left→Down→Right→Up.
  - Right press (CW): Up→Right→Down→Left→Up.
- Each cycle, in priority order:
  1. `restart`=1: heading <= Right, keydown <= 0. Any press event in the same cycle is discarded.
  2. Both press events in the same cycle: no change, keydown <= 0.
  3. Exactly one press event: heading <= rotated value, keydown <= 1.
  4. Else: keydown <= 0.
- Holding one button never repeats. Pressing the other button while one is held is a normal event.
- No 180° reversal is possible by construction; only ±90° steps are produced.
- Reset values: code=4'h4, keydown=0, all synchroniser and stable regs 1, counters 0, edge regs 1.
- Reset asserted mid-debounce or mid-strobe: everything returns to reset values on that edge; no pending event survives.

## Timing
- Raw press sampled at edge T → sync output at T+2 → stable updates at T+2+DEBOUNCE_CYCLES → `code`/`keydown` update at T+3+DEBOUNCE_CYCLES. This assumes the raw level is held throughout.
- `keydown` is exactly 1 cycle wide; `code` is valid on the same cycle and holds until the next event or restart.
- `restart` acts on the next edge: code=4'h4 one cycle after the pulse.
- Minimum spacing between two events from the same button: 2·DEBOUNCE_CYCLES (press debounce plus release debounce).
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
DEBOUNCE_CYCLES=4 for all scenarios.
- Reset: hold rst=0 for 3 cycles with buttons released → code=4'h4 and keydown=0 throughout and after release. Hold `btn`=0 during reset → no event within 10 cycles of reset release until after the debounce completes.
- Single left press: drive `btn` low at edge T, held for 20 cycles → keydown=1 only at T+7, code=4'h7 (Up) from T+7. Release then press again → code=4'h2 (Left).
- Bounce rejection: toggle `btn` low/high every 2 cycles for 20 cycles, then hold high → no keydown, code stays 4'h4. Glitches shorter than 4 cycles are ignored.
- Full rotation: 4 clean `btn1` presses from reset → codes 4'h3, 4'h2, 4'h7, 4'h4 in order with 4 single-cycle strobes. 4 clean `btn` presses → 4'h7, 4'h2, 4'h3, 4'h4.
- Simultaneous and hold: press both on the same edge → no strobe, code unchanged. Hold `btn` for 50 cycles → exactly one strobe. While holding `btn`, press `btn1` → one CW strobe.
- Restart priority: pulse `restart` on the exact cycle a press event would strobe → keydown stays 0 and code=4'h4. Assert rst mid-debounce (counter=2) → counter=0 and no later event.

Source files
------------

// File: rtl/key_steer.sv
// Two-button relative steering: synchronise and debounce each button, then
// rotate the absolute heading by 90 degrees on each press and strobe keydown.
//
// state      | meaning
// -----------+---------------------------------
// KEY_RIGHT  | heading right (reset / restart)
// KEY_DOWN   | heading down
// KEY_LEFT   | heading left
// KEY_UP     | heading up
module key_steer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       btn1,
    input  logic       restart,
    output logic [3:0] code,
    output logic       keydown
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        KEY_LEFT  = 4'h2,
        KEY_DOWN  = 4'h3,
        KEY_RIGHT = 4'h4,
        KEY_UP    = 4'h7
    } heading_t;

    // Bit 0 is the left-steer button, bit 1 the right-steer button.
    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    stable;
    logic [1:0]    stable_q;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;

    heading_t heading, heading_nxt;
    logic     keydown_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a   <= 2'b11;
            sync_b   <= 2'b11;
            stable   <= 2'b11;
            stable_q <= 2'b11;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync_a   <= {btn1, btn};
            sync_b   <= sync_a;
            stable_q <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync_b[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the released-to-pressed transition counts as an event.
    assign press = stable_q & ~stable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            heading <= KEY_RIGHT;
            keydown <= 1'b0;
        end else begin
            heading <= heading_nxt;
            keydown <= keydown_nxt;
        end
    end

    always_comb begin
        heading_nxt = heading;
        keydown_nxt = 1'b0;
        if (restart) begin
            heading_nxt = KEY_RIGHT;
        end else if (press == 2'b01) begin
            keydown_nxt = 1'b1;
            case (heading)
                KEY_UP:    heading_nxt = KEY_LEFT;
                KEY_LEFT:  heading_nxt = KEY_DOWN;
                KEY_DOWN:  heading_nxt = KEY_RIGHT;
                default:   heading_nxt = KEY_UP;
            endcase
        end else if (press == 2'b10) begin
            keydown_nxt = 1'b1;
            case (heading)
                KEY_UP:    heading_nxt = KEY_RIGHT;
                KEY_RIGHT: heading_nxt = KEY_DOWN;
                KEY_DOWN:  heading_nxt = KEY_LEFT;
                default:   heading_nxt = KEY_UP;
            endcase
        end
    end

    assign code = heading;

endmodule

// File: tb/tb_key_steer.sv
// Directed bench for key_steer with a small debounce window; expected codes
// are queued when a press is driven and popped when keydown strobes.
module tb_key_steer;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b1;
    logic       btn1 = 1'b1;
    logic       restart = 1'b0;
    logic [3:0] code;
    logic       keydown;

    int         errors = 0;
    int         checks = 0;
    int         strobe_cnt = 0;
    logic [3:0] model_h = 4'h4;
    logic [3:0] exp_q[$];

    key_steer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn(btn), .btn1(btn1),
        .restart(restart), .code(code), .keydown(keydown)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (keydown === 1'b1) strobe_cnt++;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] rot_ccw(input logic [3:0] h);
        case (h)
            4'h7:    return 4'h2;
            4'h2:    return 4'h3;
            4'h3:    return 4'h4;
            default: return 4'h7;
        endcase
    endfunction

    function automatic logic [3:0] rot_cw(input logic [3:0] h);
        case (h)
            4'h7:    return 4'h4;
            4'h4:    return 4'h3;
            4'h3:    return 4'h2;
            default: return 4'h7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("reset_code", {28'd0, code}, 32'h4);
            chk("reset_keydown", {31'd0, keydown}, 32'h0);
        end
        @(posedge clk); #1 rst = 1'b1;
        model_h = 4'h4;
        exp_q.delete();
    endtask

    // Edge count (after the driving edge) at which keydown is first seen; 0 = never.
    task automatic wait_strobe(input int max_cyc, output int k);
        k = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk); @(negedge clk);
            if (keydown === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic check_pop(input int k);
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (k != 0) chk("strobe_code", {28'd0, code}, {28'd0, e});
        end
    endtask

    task automatic press(input int which, input int hold);
        int k;
        @(posedge clk); #1;
        if (which == 0) begin
            btn = 1'b0;
            model_h = rot_ccw(model_h);
        end else begin
            btn1 = 1'b0;
            model_h = rot_cw(model_h);
        end
        exp_q.push_back(model_h);
        wait_strobe(12, k);
        chk("press_latency", k, 7);
        check_pop(k);
        @(posedge clk); @(negedge clk);
        chk("strobe_width", {31'd0, keydown}, 32'h0);
        chk("code_hold", {28'd0, code}, {28'd0, model_h});
        repeat (hold - k - 1) @(posedge clk);
        #1;
        if (which == 0) btn = 1'b1; else btn1 = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        int k;
        int s;

        // Reset with buttons released, then check idle after release.
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_reset_code", {28'd0, code}, 32'h4);
        chk("post_reset_strobes", strobe_cnt, 0);

        // Button held through reset: event only after a full debounce.
        btn = 1'b0;
        do_reset();
        exp_q.push_back(rot_ccw(4'h4));
        model_h = rot_ccw(4'h4);
        wait_strobe(12, k);
        chk("held_reset_latency", k, 7);
        check_pop(k);
        @(posedge clk); #1 btn = 1'b1;
        repeat (10) @(posedge clk);

        // Single left press, then a second one.
        do_reset();
        press(0, 20);
        chk("left1_code", {28'd0, code}, 32'h7);
        press(0, 20);
        chk("left2_code", {28'd0, code}, 32'h2);

        // Bounce every 2 cycles, then 3-cycle glitch: both rejected.
        do_reset();
        s = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 btn = ~btn;
            @(posedge clk);
        end
        @(posedge clk); #1 btn = 1'b1;
        repeat (10) @(posedge clk);
        #1 btn = 1'b0;
        repeat (3) @(posedge clk);
        #1 btn = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bounce_strobes", strobe_cnt, s);
        chk("bounce_code", {28'd0, code}, 32'h4);

        // Full CW then CCW rotations.
        do_reset();
        for (int i = 0; i < 4; i++) press(1, 12);
        chk("cw_full_code", {28'd0, code}, 32'h4);
        for (int i = 0; i < 4; i++) press(0, 12);
        chk("ccw_full_code", {28'd0, code}, 32'h4);

        // Simultaneous presses cancel.
        s = strobe_cnt;
        @(posedge clk); #1 btn = 1'b0; btn1 = 1'b0;
        repeat (20) @(posedge clk);
        #1 btn = 1'b1; btn1 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("simul_strobes", strobe_cnt, s);
        chk("simul_code", {28'd0, code}, 32'h4);

        // Long hold gives one strobe; other button while held is a normal event.
        s = strobe_cnt;
        @(posedge clk); #1 btn = 1'b0;
        model_h = rot_ccw(model_h);
        exp_q.push_back(model_h);
        wait_strobe(12, k);
        chk("hold_latency", k, 7);
        check_pop(k);
        repeat (43) @(posedge clk);
        @(negedge clk);
        chk("hold_single_strobe", strobe_cnt, s + 1);
        press(1, 20);
        chk("held_cw_code", {28'd0, code}, 32'h4);
        @(posedge clk); #1 btn = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("hold_total_strobes", strobe_cnt, s + 2);

        // Restart on the exact cycle a press would strobe.
        do_reset();
        press(1, 12);
        chk("pre_restart_code", {28'd0, code}, 32'h3);
        s = strobe_cnt;
        @(posedge clk); #1 btn1 = 1'b0;
        repeat (6) @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        model_h = 4'h4;
        @(negedge clk);
        chk("restart_code", {28'd0, code}, 32'h4);
        chk("restart_keydown", {31'd0, keydown}, 32'h0);
        repeat (10) @(posedge clk);
        #1 btn1 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("restart_strobes", strobe_cnt, s);
        chk("restart_code_hold", {28'd0, code}, 32'h4);

        // Reset mid-debounce discards the pending press.
        s = strobe_cnt;
        @(posedge clk); #1 btn = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0; btn = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_strobes", strobe_cnt, s);
        chk("mid_rst_code", {28'd0, code}, 32'h4);

        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
